// File: rtl/experiment_pkg.sv
// experiment_pkg: shared state encoding and counter width for the experiment sequencer
package experiment_pkg;
  localparam int CNT_W_DEFAULT = 16;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MAC_TX   = 3'd1;
  localparam logic [2:0] S_MAC_WAIT = 3'd2;
  localparam logic [2:0] S_MAC_RX   = 3'd3;
  localparam logic [2:0] S_NL_TX    = 3'd4;
  localparam logic [2:0] S_NL_WAIT  = 3'd5;
  localparam logic [2:0] S_NL_RX    = 3'd6;
  typedef enum logic [2:0] {
    IDLE     = S_IDLE,
    MAC_TX   = S_MAC_TX,
    MAC_WAIT = S_MAC_WAIT,
    MAC_RX   = S_MAC_RX,
    NL_TX    = S_NL_TX,
    NL_WAIT  = S_NL_WAIT,
    NL_RX    = S_NL_RX
  } state_e;
endpackage

// File: rtl/seq_counter.sv
// seq_counter: up counter with clear, enable and terminal-count compare
module seq_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear wins over enable
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + W'(1) : cnt_q;
  // count register, active-low async reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == last_i;
endmodule

// File: rtl/experiment_sequencer.sv
// experiment_sequencer: per-round MAC then NL transmit/gap/capture sequencing for N rounds
module experiment_sequencer import experiment_pkg::*; #(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_num_beats,
  input  logic [CNT_W-1:0] cfg_latency,
  input  logic [CNT_W-1:0] cfg_num_rounds,
  input  logic             mac_dac_ready,
  input  logic             nl_dac_ready,
  input  logic             mac_adc_valid,
  input  logic             nl_adc_valid,
  output logic             mac_dac_en,
  output logic             nl_dac_en,
  output logic             mac_adc_cap,
  output logic             nl_adc_cap,
  output logic [CNT_W-1:0] beat_idx,
  output logic [CNT_W-1:0] round_idx,
  output logic [2:0]       state_o,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d, l_q, l_d, n_q, n_d, bcnt, blast;
  logic done_q, done_d, err_q, err_d;
  logic bclr, ben, btc, rclr, ren, rtc, xfer, in_wait;
  assign in_wait = state_q == MAC_WAIT || state_q == NL_WAIT;
  assign xfer = (state_q == MAC_TX && mac_dac_ready) || (state_q == NL_TX && nl_dac_ready) ||
                (state_q == MAC_RX && mac_adc_valid) || (state_q == NL_RX && nl_adc_valid);
  assign blast = in_wait ? l_q - CNT_W'(1) : k_q - CNT_W'(1);
  seq_counter #(.W(CNT_W)) u_beat (
    .clk(clk), .rst(rst), .clr_i(bclr), .en_i(ben), .last_i(blast), .cnt_o(bcnt), .tc_o(btc)
  );
  seq_counter #(.W(CNT_W)) u_round (
    .clk(clk), .rst(rst), .clr_i(rclr), .en_i(ren), .last_i(n_q - CNT_W'(1)), .cnt_o(round_idx), .tc_o(rtc)
  );
  // next-state, counter control, config latch and sticky flags
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    l_d = l_q;
    n_d = n_q;
    done_d = done_q;
    err_d = err_q;
    bclr = 1'b0;
    ben = 1'b0;
    rclr = 1'b0;
    ren = 1'b0;
    if (cfg_abort) begin
      state_d = IDLE;
      bclr = 1'b1;
      rclr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          bclr = 1'b1;
          rclr = 1'b1;
          if (cfg_start) begin
            k_d = cfg_num_beats;
            l_d = cfg_latency;
            n_d = cfg_num_rounds;
            if (cfg_num_beats == '0 || cfg_num_rounds == '0) err_d = 1'b1;
            else begin
              done_d = 1'b0;
              err_d = 1'b0;
              state_d = MAC_TX;
            end
          end
        end
        MAC_TX, NL_TX: begin
          ben = xfer;
          if (xfer && btc) begin
            bclr = 1'b1;
            state_d = state_q == MAC_TX ? (l_q == '0 ? MAC_RX : MAC_WAIT)
                                        : (l_q == '0 ? NL_RX : NL_WAIT);
          end
        end
        MAC_WAIT, NL_WAIT: begin
          ben = 1'b1;
          if (btc) begin
            bclr = 1'b1;
            state_d = state_q == MAC_WAIT ? MAC_RX : NL_RX;
          end
        end
        MAC_RX: begin
          ben = xfer;
          if (xfer && btc) begin
            bclr = 1'b1;
            state_d = NL_TX;
          end
        end
        NL_RX: begin
          ben = xfer;
          if (xfer && btc) begin
            bclr = 1'b1;
            ren = !rtc;
            done_d = rtc ? 1'b1 : done_q;
            state_d = rtc ? IDLE : MAC_TX;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state, latched config and flags, active-low async reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      k_q <= '0;
      l_q <= '0;
      n_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      l_q <= l_d;
      n_q <= n_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  assign mac_dac_en  = state_q == MAC_TX;
  assign nl_dac_en   = state_q == NL_TX;
  assign mac_adc_cap = state_q == MAC_RX;
  assign nl_adc_cap  = state_q == NL_RX;
  assign beat_idx    = in_wait ? '0 : bcnt;
  assign state_o     = state_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign cfg_err     = err_q;
endmodule

// File: tb/tb_experiment_sequencer.sv
// tb_experiment_sequencer: table-driven full runs plus directed stall, error, abort and reset sequences
module tb_experiment_sequencer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [W-1:0] cfg_num_beats = '0, cfg_latency = '0, cfg_num_rounds = '0;
  logic mac_dac_ready = 1'b1, nl_dac_ready = 1'b1, mac_adc_valid = 1'b1, nl_adc_valid = 1'b1;
  logic mac_dac_en, nl_dac_en, mac_adc_cap, nl_adc_cap, busy, done, cfg_err;
  logic [W-1:0] beat_idx, round_idx;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
  int busy_c, mtx, mrx, ntx, nrx, gap, rx0, maxr, dcyc, done1, done_end, err1;
  typedef struct {int k; int l; int n; int busy; int rx0;} vec_t;
  vec_t tab[6];
  experiment_sequencer #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_beats(cfg_num_beats), .cfg_latency(cfg_latency), .cfg_num_rounds(cfg_num_rounds),
    .mac_dac_ready(mac_dac_ready), .nl_dac_ready(nl_dac_ready),
    .mac_adc_valid(mac_adc_valid), .nl_adc_valid(nl_adc_valid),
    .mac_dac_en(mac_dac_en), .nl_dac_en(nl_dac_en), .mac_adc_cap(mac_adc_cap), .nl_adc_cap(nl_adc_cap),
    .beat_idx(beat_idx), .round_idx(round_idx), .state_o(state_o),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #2 clk = ~clk;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [53:0] outs();
    return {mac_dac_en, nl_dac_en, mac_adc_cap, nl_adc_cap, beat_idx, round_idx, state_o, busy, done, cfg_err};
  endfunction
  task automatic go(input int k, input int l, input int n);
    int c;
    @(negedge clk);
    cfg_num_beats = W'(k);
    cfg_latency = W'(l);
    cfg_num_rounds = W'(n);
    cfg_start = 1'b1;
    {busy_c, mtx, mrx, ntx, nrx, gap, maxr} = '0;
    rx0 = -1;
    dcyc = -1;
    for (c = 1; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cfg_start = 1'b0;
        done1 = int'(done);
        err1 = int'(cfg_err);
        cfg_num_beats = 16'd7;
        cfg_latency = 16'd9;
        cfg_num_rounds = 16'd5;
      end
      if (!busy) break;
      busy_c++;
      mtx += int'(mac_dac_en);
      mrx += int'(mac_adc_cap);
      ntx += int'(nl_dac_en);
      nrx += int'(nl_adc_cap);
      gap += int'(!(mac_dac_en || nl_dac_en || mac_adc_cap || nl_adc_cap));
      if (mac_adc_cap && rx0 < 0) rx0 = c;
      if (int'(round_idx) > maxr) maxr = int'(round_idx);
    end
    chk("run_terminates", int'(busy), 0);
    dcyc = c;
    done_end = int'(done);
  endtask
  initial begin
    tab[0] = '{4, 3, 2, 44, 8};
    tab[1] = '{2, 0, 1, 8, 3};
    tab[2] = '{1, 0, 1, 4, 2};
    tab[3] = '{3, 1, 2, 28, 5};
    tab[4] = '{1, 5, 1, 14, 7};
    tab[5] = '{5, 2, 3, 72, 8};
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", outs(), 0);
    for (int i = 0; i < 6; i++) begin
      go(tab[i].k, tab[i].l, tab[i].n);
      chk($sformatf("v%0d_busy_cycles", i), busy_c, tab[i].busy);
      chk($sformatf("v%0d_done_cycle", i), dcyc, tab[i].busy + 1);
      chk($sformatf("v%0d_done", i), done_end, 1);
      chk($sformatf("v%0d_done_cleared", i), done1, 0);
      chk($sformatf("v%0d_first_mac_rx", i), rx0, tab[i].rx0);
      chk($sformatf("v%0d_window_beats", i), {mtx, mrx, ntx, nrx},
          {tab[i].n * tab[i].k, tab[i].n * tab[i].k, tab[i].n * tab[i].k, tab[i].n * tab[i].k});
      chk($sformatf("v%0d_gap_cycles", i), gap, 2 * tab[i].n * tab[i].l);
      chk($sformatf("v%0d_last_round", i), maxr, tab[i].n - 1);
    end
    begin
      logic [4:0] pat;
      int exp_b[5];
      pat = 5'b10101;
      exp_b = '{0, 1, 1, 2, 2};
      @(negedge clk);
      cfg_num_beats = 16'd3;
      cfg_latency = 16'd0;
      cfg_num_rounds = 16'd1;
      cfg_start = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        cfg_start = 1'b0;
        chk($sformatf("stall_c%0d_en", i + 1), mac_dac_en, 1);
        chk($sformatf("stall_c%0d_beat", i + 1), beat_idx, exp_b[i]);
        mac_dac_ready = pat[4 - i];
      end
      @(negedge clk);
      mac_dac_ready = 1'b1;
      chk("stall_to_mac_rx", state_o, 3);
      chk("stall_rx_beat0", beat_idx, 0);
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      chk("stall_run_done", {busy, done}, 2'b01);
    end
    @(negedge clk);
    cfg_num_beats = 16'd0;
    cfg_num_rounds = 16'd1;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("k0_cfg_err", cfg_err, 1);
    chk("k0_busy", busy, 0);
    chk("k0_state", state_o, 0);
    go(1, 0, 1);
    chk("after_err_cleared", err1, 0);
    chk("after_err_busy", busy_c, 4);
    chk("after_err_done", done_end, 1);
    @(negedge clk);
    cfg_num_beats = 16'd2;
    cfg_latency = 16'd2;
    cfg_num_rounds = 16'd3;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 200 && !(round_idx == 16'd1 && state_o == 3'd5); i++) @(negedge clk);
    chk("reached_nl_wait_r1", {round_idx, state_o}, {16'd1, 3'd5});
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    chk("abort_idle", {state_o, busy, done, round_idx, beat_idx}, 0);
    @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    cfg_num_beats = 16'd0;
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    chk("start_abort_nothing", {busy, cfg_err, done}, 0);
    @(negedge clk);
    cfg_num_beats = 16'd4;
    cfg_latency = 16'd1;
    cfg_num_rounds = 16'd2;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 100 && state_o != 3'd3; i++) @(negedge clk);
    chk("reached_mac_rx", state_o, 3);
    #1 rst = 1'b0;
    #1 chk("async_reset_outputs", outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    go(2, 0, 1);
    chk("post_reset_busy", busy_c, 8);
    chk("post_reset_done", done_end, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/experiment_sequencer.md
# experiment_sequencer

Round-level controller for the Ising machine datapath. It sequences each iteration as follows: a MAC transmit window on DACs A/B/C, a programmable optical/analog latency gap, and a MAC capture window on the MAC ADC. It then repeats the same transmit, gap and capture pattern for the NL path (A NL DAC → NL ADC), for N rounds. It sits between the GPIO control/status registers and the DAC/ADC stream logic of the experiment top level, and drives only enables and indices; it does not touch sample data.

## Interface
- CNT_W, 16, width of beat, latency and round counters and their config inputs
- clk  in  1  system clock (250 MHz)
- rst  in  1  asynchronous, active-low reset
- cfg_start  in  1  single-cycle start pulse (from gpio_in)
- cfg_abort  in  1  single-cycle abort pulse
- cfg_num_beats  in  CNT_W  K, beats per window; must be ≥1
- cfg_latency  in  CNT_W  L, gap cycles between last TX beat and RX window; 0 allowed
- cfg_num_rounds  in  CNT_W  N, rounds per run; must be ≥1
- mac_dac_ready  in  1  AND of m0/m1/m2 tready
- nl_dac_ready  in  1  m3 tready
- mac_adc_valid  in  1  s0 tvalid
- nl_adc_valid  in  1  s1 tvalid
- mac_dac_en  out  1  drive A/B/C tvalid; reset 0
- nl_dac_en  out  1  drive A NL tvalid; reset 0
- mac_adc_cap  out  1  capture s0 beats; reset 0
- nl_adc_cap  out  1  capture s1 beats; reset 0
- beat_idx  out  CNT_W  beat index within current window; reset 0
- round_idx  out  CNT_W  current round; reset 0
- state_o  out  3  encoded state for gpio_out_bus; reset IDLE
- busy  out  1  high in any non-IDLE state; reset 0
- done  out  1  sticky, set on normal completion, cleared by next accepted start; reset 0
- cfg_err  out  1  sticky, set on start with K=0 or N=0, cleared by next accepted start; reset 0

## Operation
- States: IDLE, MAC_TX, MAC_WAIT, MAC_RX, NL_TX, NL_WAIT, NL_RX.
- IDLE + cfg_start (no abort): cfg_num_beats, cfg_latency and cfg_num_rounds are latched. If K=0 or N=0, cfg_err←1 and the block stays IDLE. Otherwise the start is accepted: done←0, cfg_err←0, round_idx←0, beat_idx←0, state→MAC_TX.
- TX states: a beat transfers in any cycle with the enable high and the matching ready high; beat_idx increments on each transfer. The transfer at beat_idx=K-1 clears beat_idx and moves to *_WAIT, or directly to *_RX when L=0.
- WAIT states: all enables low for exactly L cycles, then *_RX.
- RX states: a beat is captured in any cycle with cap high and the matching valid high. The capture at beat_idx=K-1 clears beat_idx. MAC_RX then goes to NL_TX.
- NL_RX end: if round_idx=N-1, state→IDLE and done←1; else round_idx++ and state→MAC_TX.
- cfg_start while busy is ignored.
- cfg_abort in any state: next state is IDLE with counters cleared; done is not set.
- cfg_start and cfg_abort together in IDLE: abort wins and nothing is latched.
- Changes to the cfg_* inputs while busy have no effect, because the values are latched at start.
- rst asserted mid-run forces all outputs to their reset values immediately.

## Timing
- Enables and cap are a Moore decode of the state register only; there is no combinational path from ready/valid to any output.
- Start sampled at edge 0 → MAC_TX (mac_dac_en=1, busy=1) from cycle 1.
- With ready/valid held high, one round lasts 4K+2L cycles; the run lasts N·(4K+2L) cycles.
- done rises on the first cycle after the last NL capture, together with busy falling.
- A ready or valid low stalls the window and holds beat_idx; the wait counter never stalls.

## Structure
- Shared package experiment_pkg: state encoding localparams (3-bit), CNT_W default.
- One sub-module, seq_counter: a CNT_W counter with clear, enable and terminal-count flag, instantiated separately for the beat/latency count and for the round count.

## Test plan
- K=4, L=3, N=2, all ready/valid=1, start at cycle 0 → mac_dac_en in cycles 1–4, MAC_RX in cycles 8–11, NL_TX in cycles 12–15, busy for 44 cycles, done=1 at cycle 45, round_idx sequence 0→1.
- K=2, L=0, N=1 → MAC_TX goes directly to MAC_RX with no gap cycle; total 8 busy cycles.
- K=3, mac_dac_ready toggling 1,0,1,0,1 → beat_idx holds during low cycles, and MAC_TX lasts 5 cycles.
- Start with K=0 → cfg_err=1, busy stays 0. A following start with K=1, N=1, L=0 clears cfg_err and completes with done=1.
- Abort in NL_WAIT of round 1 (N=3) → IDLE the next cycle, done=0, round_idx=0. Start and abort in the same cycle in IDLE → nothing happens.
- rst pulsed low during MAC_RX → all outputs return to reset values asynchronously; a fresh start then runs normally.
